// File: rtl/mc_bus_arb.sv
// mc_bus_arb: round-robin internal memory-bus arbiter with hold-limit preemption and external br/bg handover
module mc_bus_arb #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                    mc_clk,
  input  logic                    mc_rst_n,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ-1:0]         done_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  output logic                    busy_o,
  output logic                    preempt_o,
  input  logic                    mc_br_i,
  output logic                    mc_bg_o
);
  localparam int W = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, GRANT, EXT} state_t;
  state_t state, state_n;
  logic [NREQ-1:0] gnt_n;
  logic [W-1:0] owner_n, last, last_n, pick;
  logic [7:0] hold, hold_n;
  logic bg_n, pre_n, rel, limit, rival;
  function automatic logic [W-1:0] wrap(input logic [W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return W'(s >= NREQ ? s - NREQ : s);
  endfunction
  always_comb begin
    pick = last;
    for (int i = NREQ; i >= 1; i--) pick = req_i[wrap(last, i)] ? wrap(last, i) : pick;
  end
  assign rel    = done_i[owner_o] | ~req_i[owner_o];
  assign limit  = hold >= 8'(MAX_HOLD - 1);
  assign rival  = mc_br_i | (|(req_i & ~gnt_o));
  assign busy_o = (|gnt_o) | mc_bg_o;
  always_comb begin
    state_n = state;
    gnt_n   = gnt_o;
    owner_n = owner_o;
    last_n  = last;
    hold_n  = hold;
    bg_n    = 1'b0;
    pre_n   = 1'b0;
    case (state)
      IDLE: begin
        hold_n = '0;
        if (mc_br_i) begin
          state_n = EXT;
          bg_n    = 1'b1;
        end else if (|req_i) begin
          state_n = GRANT;
          owner_n = pick;
          gnt_n   = NREQ'(1) << pick;
        end
      end
      GRANT: begin
        hold_n = hold == 8'(MAX_HOLD) ? hold : hold + 8'd1;
        if (rel | (limit & rival)) begin
          state_n = IDLE;
          gnt_n   = '0;
          last_n  = owner_o;
          pre_n   = ~rel;
        end
      end
      EXT: begin
        bg_n    = mc_br_i;
        state_n = mc_br_i ? EXT : IDLE;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end
  always_ff @(posedge mc_clk or negedge mc_rst_n) begin
    if (!mc_rst_n) begin
      state     <= IDLE;
      gnt_o     <= '0;
      owner_o   <= '0;
      last      <= W'(NREQ - 1);
      hold      <= '0;
      mc_bg_o   <= 1'b0;
      preempt_o <= 1'b0;
    end else begin
      state     <= state_n;
      gnt_o     <= gnt_n;
      owner_o   <= owner_n;
      last      <= last_n;
      hold      <= hold_n;
      mc_bg_o   <= bg_n;
      preempt_o <= pre_n;
    end
  end
endmodule

// File: tb/tb_mc_bus_arb.sv
// tb_mc_bus_arb: scoreboard bench for mc_bus_arb with a behavioural reference model
module tb_mc_bus_arb;
  localparam int NREQ = 4;
  localparam int MAX_HOLD = 16;
  logic mc_clk = 1'b0;
  logic mc_rst_n = 1'b0;
  logic [3:0] req_i = '0;
  logic [3:0] done_i = '0;
  logic [3:0] gnt_o;
  logic [1:0] owner_o;
  logic busy_o, preempt_o, mc_bg_o;
  logic mc_br_i = 1'b0;
  always #5 mc_clk = ~mc_clk;
  mc_bus_arb #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .mc_clk(mc_clk), .mc_rst_n(mc_rst_n), .req_i(req_i), .done_i(done_i),
    .gnt_o(gnt_o), .owner_o(owner_o), .busy_o(busy_o), .preempt_o(preempt_o),
    .mc_br_i(mc_br_i), .mc_bg_o(mc_bg_o)
  );
  typedef struct {logic [3:0] gnt; logic [1:0] own; logic bg; logic pre;} exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int m_st, m_own, m_last, m_cyc;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset;
    m_st = 0;
    m_own = 0;
    m_last = NREQ - 1;
    m_cyc = 0;
    sb.delete();
  endtask
  task automatic model_step(input logic [3:0] r, input logic [3:0] d, input logic b);
    exp_t e;
    bit pre, found;
    pre = 0;
    found = 0;
    case (m_st)
      0: if (b) m_st = 2;
         else if (r != 0) begin
           for (int k = 1; k <= NREQ; k++)
             if (!found && r[(m_last + k) % NREQ]) begin
               found = 1;
               m_own = (m_last + k) % NREQ;
             end
           m_st = 1;
           m_cyc = 1;
         end
      1: if (d[m_own] || !r[m_own]) begin
           m_st = 0;
           m_last = m_own;
         end else if (m_cyc >= MAX_HOLD && (b || (r & ~(4'b1 << m_own)) != 0)) begin
           m_st = 0;
           m_last = m_own;
           pre = 1;
         end else m_cyc++;
      default: if (!b) m_st = 0;
    endcase
    e.gnt = m_st == 1 ? 4'b1 << m_own : 4'b0;
    e.own = 2'(m_own);
    e.bg = m_st == 2;
    e.pre = pre;
    sb.push_back(e);
  endtask
  task automatic cyc(input logic [3:0] r, input logic [3:0] d, input logic b);
    exp_t e;
    req_i = r;
    done_i = d;
    mc_br_i = b;
    model_step(r, d, b);
    @(posedge mc_clk);
    #1;
    e = sb.pop_front();
    check("gnt", gnt_o, e.gnt);
    check("bg", mc_bg_o, e.bg);
    check("preempt", preempt_o, e.pre);
    check("busy", busy_o, (e.gnt != 0) || e.bg);
    if (e.gnt != 0) check("owner", owner_o, e.own);
  endtask
  initial begin
    int gcnt, gc, pc, bg_at, g1, bgc;
    int order[$];
    logic [3:0] d;
    model_reset();
    repeat (2) @(posedge mc_clk);
    #1;
    check("rst_gnt", gnt_o, 0);
    check("rst_bg", mc_bg_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_pre", preempt_o, 0);
    check("rst_owner", owner_o, 0);
    mc_rst_n = 1'b1;
    gcnt = 0;
    for (int t = 0; t < 22; t++) begin
      d = (gcnt == 3) ? gnt_o : 4'b0;
      cyc(4'hF, d, 1'b0);
      if (gnt_o != 0) begin
        if (gcnt == 0) order.push_back(int'(owner_o));
        gcnt++;
      end else gcnt = 0;
    end
    check("rr_count", order.size() >= 5, 1);
    for (int i = 0; i < 5 && i < order.size(); i++) check("rr_order", order[i], i % 4);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'b0010, 4'h0, 1'b1);
    check("ext_bg", mc_bg_o, 1);
    check("ext_gnt", gnt_o, 0);
    cyc(4'b0010, 4'h0, 1'b1);
    cyc(4'b0010, 4'h0, 1'b0);
    check("ext_drop", mc_bg_o, 0);
    cyc(4'b0010, 4'h0, 1'b0);
    check("ext_then_gnt", gnt_o, 4'b0010);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'b0100, 4'h0, 1'b0);
    check("pre_first", gnt_o, 4'b0100);
    gc = 1;
    pc = 0;
    bg_at = -1;
    for (int t = 0; t < 25; t++) begin
      cyc(4'b0100, 4'h0, 1'b1);
      if (gnt_o == 4'b0100) gc++;
      if (preempt_o) begin
        pc++;
        check("pre_gnt_low", gnt_o, 0);
      end
      if (mc_bg_o && bg_at < 0) bg_at = t;
    end
    check("pre_cycles", gc, MAX_HOLD);
    check("pre_pulses", pc, 1);
    check("pre_bg_at", bg_at, MAX_HOLD);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    pc = 0;
    g1 = 0;
    for (int t = 0; t < 40; t++) begin
      cyc(4'b0001, 4'h0, 1'b0);
      pc += int'(preempt_o);
      g1 += int'(gnt_o == 4'b0001);
    end
    check("lone_pre", pc, 0);
    check("lone_gnt", g1, 40);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'b0011, 4'h0, 1'b0);
    for (int t = 0; t < MAX_HOLD - 1; t++) cyc(4'b0011, 4'h0, 1'b0);
    check("dl_hold", gnt_o, 4'b0010);
    cyc(4'b0011, 4'b0010, 1'b0);
    check("dl_pre", preempt_o, 0);
    check("dl_gnt", gnt_o, 0);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'b0001, 4'h0, 1'b0);
    check("no_first", gnt_o, 4'b0001);
    cyc(4'b0001, 4'b0010, 1'b0);
    check("nonowner_done", gnt_o, 4'b0001);
    cyc(4'h0, 4'h0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0);
    bgc = 0;
    cyc(4'h0, 4'h0, 1'b1);
    bgc += int'(mc_bg_o);
    for (int t = 0; t < 3; t++) begin
      cyc(4'h0, 4'h0, 1'b0);
      bgc += int'(mc_bg_o);
    end
    check("br_pulse", bgc, 1);
    cyc(4'b0100, 4'h0, 1'b0);
    check("mid_gnt", gnt_o, 4'b0100);
    #3;
    mc_rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", gnt_o, 0);
    check("mid_rst_bg", mc_bg_o, 0);
    check("mid_rst_busy", busy_o, 0);
    model_reset();
    req_i = '0;
    @(posedge mc_clk);
    #1;
    mc_rst_n = 1'b1;
    cyc(4'hF, 4'h0, 1'b0);
    check("rst_first", gnt_o, 4'b0001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
